// File: rtl/fixed_point_add_sub.sv
// rtl/fixed_point_add_sub.sv - signed fixed-point add/subtract with overflow detection and start/done handshake
//
// Purpose:
//   Captures two two's-complement operands and an add/sub select on an accepted
//   i_start. One cycle later it registers A+B or A-B, the signed overflow flag,
//   and a one-cycle o_done pulse. On overflow the result either saturates
//   (SATURATE=1) or wraps (SATURATE=0).
//
// Ports:
//   i_clk        rising-edge clock
//   i_rst        asynchronous active-low reset
//   i_start      operation request, honoured only while idle
//   i_sub        0 = A+B, 1 = A-B, captured together with the operands
//   i_operandA   signed operand A
//   i_operandB   signed operand B
//   o_data       registered result
//   o_overflow   signed overflow flag belonging to o_data
//   o_valid      o_data/o_overflow hold a completed result
//   o_done       one-cycle completion pulse
//   o_busy       operation in flight; i_start is ignored while high
module fixed_point_add_sub #(
   parameter int DATA_WIDTH = 8,
   parameter int FRAC_BITS  = 4,
   parameter int SATURATE   = 1
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_start,
   input  logic                  i_sub,
   input  logic [DATA_WIDTH-1:0] i_operandA,
   input  logic [DATA_WIDTH-1:0] i_operandB,
   output logic [DATA_WIDTH-1:0] o_data,
   output logic                  o_overflow,
   output logic                  o_valid,
   output logic                  o_done,
   output logic                  o_busy
);

   // FRAC_BITS only labels the Q format; an out-of-range value shows up as
   // this named scope in the elaborated hierarchy.
   if (FRAC_BITS < 0 || FRAC_BITS >= DATA_WIDTH) begin : g_frac_bits_out_of_range
   end

   typedef enum logic {
      IDLE = 1'b0,
      EXEC = 1'b1
   } state_t;

   state_t                r_state;
   state_t                w_next_state;

   logic [DATA_WIDTH-1:0] r_a;
   logic [DATA_WIDTH-1:0] r_b;
   logic                  r_sub;

   logic [DATA_WIDTH:0]   w_a_ext;
   logic [DATA_WIDTH:0]   w_b_ext;
   logic [DATA_WIDTH:0]   w_sum;
   logic                  w_overflow;
   logic [DATA_WIDTH-1:0] w_result;

   localparam logic [DATA_WIDTH-1:0] MAX_POS = {1'b0, {(DATA_WIDTH-1){1'b1}}};
   localparam logic [DATA_WIDTH-1:0] MIN_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

   // One extra bit holds the exact result of any add/sub of two W-bit values.
   assign w_a_ext = {r_a[DATA_WIDTH-1], r_a};
   assign w_b_ext = {r_b[DATA_WIDTH-1], r_b};
   assign w_sum   = r_sub ? (w_a_ext - w_b_ext) : (w_a_ext + w_b_ext);

   always_comb begin
      w_overflow = 1'b0;
      if (r_sub) begin
         w_overflow = (r_a[DATA_WIDTH-1] != r_b[DATA_WIDTH-1]) &&
                      (w_sum[DATA_WIDTH-1] != r_a[DATA_WIDTH-1]);
      end else begin
         w_overflow = (r_a[DATA_WIDTH-1] == r_b[DATA_WIDTH-1]) &&
                      (w_sum[DATA_WIDTH-1] != r_a[DATA_WIDTH-1]);
      end
   end

   // On overflow the wide sum's top bit is the true sign, which always equals
   // A's sign, so it picks the clamp direction.
   always_comb begin
      w_result = w_sum[DATA_WIDTH-1:0];
      if (w_overflow && (SATURATE != 0)) begin
         w_result = w_sum[DATA_WIDTH] ? MIN_NEG : MAX_POS;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE:    if (i_start) w_next_state = EXEC;
         EXEC:    w_next_state = IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_a        <= '0;
         r_b        <= '0;
         r_sub      <= 1'b0;
         o_data     <= '0;
         o_overflow <= 1'b0;
         o_valid    <= 1'b0;
         o_done     <= 1'b0;
         o_busy     <= 1'b0;
      end else begin
         o_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (i_start) begin
                  r_a     <= i_operandA;
                  r_b     <= i_operandB;
                  r_sub   <= i_sub;
                  o_busy  <= 1'b1;
                  o_valid <= 1'b0;
               end
            end
            EXEC: begin
               o_data     <= w_result;
               o_overflow <= w_overflow;
               o_done     <= 1'b1;
               o_valid    <= 1'b1;
               o_busy     <= 1'b0;
            end
            default: begin
               o_busy <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fixed_point_add_sub.sv
// tb/tb_fixed_point_add_sub.sv - scoreboard bench for fixed_point_add_sub, saturating and wrapping instances
module tb_fixed_point_add_sub;

   typedef struct packed {
      logic [7:0] sat_data;
      logic [7:0] wrap_data;
      logic       ovf;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start = 1'b0;
   logic       sub = 1'b0;
   logic [7:0] opa = 8'h00;
   logic [7:0] opb = 8'h00;

   logic [7:0] s_data, w_data;
   logic       s_ovf, s_valid, s_done, s_busy;
   logic       w_ovf, w_valid, w_done, w_busy;

   int   checks = 0;
   int   fails  = 0;
   exp_t exp_q[$];

   bit   model_busy  = 1'b0;
   bit   model_done  = 1'b0;
   bit   model_valid = 1'b0;

   always #5 clk = ~clk;

   fixed_point_add_sub #(.DATA_WIDTH(8), .FRAC_BITS(4), .SATURATE(1)) dut_sat (
      .i_clk(clk), .i_rst(rst), .i_start(start), .i_sub(sub),
      .i_operandA(opa), .i_operandB(opb),
      .o_data(s_data), .o_overflow(s_ovf), .o_valid(s_valid), .o_done(s_done), .o_busy(s_busy)
   );

   fixed_point_add_sub #(.DATA_WIDTH(8), .FRAC_BITS(4), .SATURATE(0)) dut_wrap (
      .i_clk(clk), .i_rst(rst), .i_start(start), .i_sub(sub),
      .i_operandA(opa), .i_operandB(opb),
      .o_data(w_data), .o_overflow(w_ovf), .o_valid(w_valid), .o_done(w_done), .o_busy(w_busy)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: exact integer arithmetic, then range-check against Q3.4 limits.
   function automatic exp_t ref_model(input logic [7:0] a, input logic [7:0] b, input bit s);
      exp_t e;
      int   ia, ib, r;
      ia = int'($signed(a));
      ib = int'($signed(b));
      r  = s ? (ia - ib) : (ia + ib);
      e.ovf       = (r > 127) || (r < -128);
      e.wrap_data = 8'(r);
      if (r > 127)       e.sat_data = 8'h7F;
      else if (r < -128) e.sat_data = 8'h80;
      else               e.sat_data = 8'(r);
      return e;
   endfunction

   // Drive one cycle of inputs, let the rising edge happen, then advance the
   // handshake model: an operation occupies exactly the edge after its accept.
   task automatic step(input bit st, input logic [7:0] a, input logic [7:0] b, input bit s);
      bit accepted;
      start = st; opa = a; opb = b; sub = s;
      @(posedge clk);
      accepted   = rst && st && !model_busy;
      model_done = rst && model_busy;
      model_busy = accepted;
      if (!rst || accepted) model_valid = 1'b0;
      else if (model_done)  model_valid = 1'b1;
      if (accepted) exp_q.push_back(ref_model(a, b, s));
      #1;
   endtask

   // Start, then scramble the inputs while the captured values are executing.
   task automatic op(input logic [7:0] a, input logic [7:0] b, input bit s);
      step(1'b1, a, b, s);
      step(1'b0, ~a, ~b, ~s);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 8'($urandom), 8'($urandom), 1'($urandom));
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, " data"}, {24'd0, s_data}, 32'd0);
      chk({tag, " ovf"},  {31'd0, s_ovf},  32'd0);
      chk({tag, " valid"}, {31'd0, s_valid}, 32'd0);
      chk({tag, " done"}, {31'd0, s_done}, 32'd0);
      chk({tag, " busy"}, {31'd0, s_busy}, 32'd0);
      chk({tag, " wrap data"}, {24'd0, w_data}, 32'd0);
      chk({tag, " wrap valid"}, {31'd0, w_valid}, 32'd0);
   endtask

   // Monitor: handshake against the model every cycle, results against the scoreboard.
   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         chk_zero("reset");
      end else begin
         chk("busy",  {31'd0, s_busy},  {31'd0, model_busy});
         chk("done",  {31'd0, s_done},  {31'd0, model_done});
         chk("valid", {31'd0, s_valid}, {31'd0, model_valid});
         chk("wrap done", {31'd0, w_done}, {31'd0, model_done});
         if (s_done) begin
            if (exp_q.size() == 0) begin
               checks++;
               fails++;
               $display("FAIL unexpected_done: got done=1 expected no pending result at %0t", $time);
            end else begin
               e = exp_q.pop_front();
               chk("sat data",  {24'd0, s_data}, {24'd0, e.sat_data});
               chk("sat ovf",   {31'd0, s_ovf},  {31'd0, e.ovf});
               chk("wrap data", {24'd0, w_data}, {24'd0, e.wrap_data});
               chk("wrap ovf",  {31'd0, w_ovf},  {31'd0, e.ovf});
            end
         end
      end
   end

   initial begin
      idle(2);
      @(posedge clk);
      #1 rst = 1'b1;

      op(8'h00, 8'h00, 1'b0);
      idle(20);

      op(8'h10, 8'h18, 1'b0);
      op(8'h10, 8'h18, 1'b1);
      op(8'h70, 8'h20, 1'b0);
      op(8'h80, 8'h01, 1'b1);
      op(8'h80, 8'h80, 1'b0);
      op(8'h7F, 8'hFF, 1'b1);
      op(8'h80, 8'h7F, 1'b0);
      idle(2);

      // Second start during EXEC with different operands must be dropped.
      step(1'b1, 8'h10, 8'h08, 1'b0);
      step(1'b1, 8'h7F, 8'h7F, 1'b0);
      idle(3);

      // Held start: one result every two cycles.
      for (int i = 0; i < 12; i++) step(1'b1, 8'($urandom), 8'($urandom), 1'($urandom));
      idle(2);

      // Reset in the middle of EXEC: outputs clear at once, no done follows.
      step(1'b1, 8'h70, 8'h20, 1'b0);
      #1 rst = 1'b0;
      #1 chk_zero("async reset");
      exp_q.delete();
      model_busy  = 1'b0;
      model_done  = 1'b0;
      model_valid = 1'b0;
      step(1'b1, 8'h11, 8'h22, 1'b0);
      step(1'b0, 8'h00, 8'h00, 1'b0);
      rst = 1'b1;
      op(8'h11, 8'h22, 1'b0);
      idle(2);

      for (int i = 0; i < 200; i++) step(1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));
      idle(3);

      chk("scoreboard drained", exp_q.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

// File: doc/fixed_point_add_sub.md
# fixed_point_add_sub

Single-operation signed fixed-point adder/subtractor with a start/done handshake. It takes two two's-complement operands, forms A+B or A−B, and detects signed overflow, saturating the result by default. It sits in the DSP filter datapath as the shared accumulate/difference element, driven by a sequencing controller.

## Interface

- DATA_WIDTH, 8: operand/result width, two's complement.
- FRAC_BITS, 4: fractional bits (Q(DATA_WIDTH−FRAC_BITS).FRAC_BITS). Documentation only; it does not change the arithmetic.
- SATURATE, 1: 1 = clamp on overflow; 0 = wrap (modular result).

- i_clk, input, 1: single clock, rising edge.
- i_rst, input, 1: asynchronous, active-low reset (0 = reset).
- i_start, input, 1: request an operation; sampled on a rising edge while idle.
- i_sub, input, 1: 0 = A+B, 1 = A−B; captured with the operands.
- i_operandA, input, DATA_WIDTH: operand A (signed).
- i_operandB, input, DATA_WIDTH: operand B (signed).
- o_data, output, DATA_WIDTH: registered result.
- o_overflow, output, 1: signed overflow flag for the result on o_data.
- o_valid, output, 1: o_data/o_overflow hold a completed result.
- o_done, output, 1: one-cycle completion pulse.
- o_busy, output, 1: operation in progress; i_start is ignored while high.

## Operation

- The FSM has two states.
  - IDLE: on i_start=1, capture i_operandA, i_operandB and i_sub into internal registers. Drive o_busy to 1, o_done to 0 and o_valid to 0. Go to EXEC.
  - EXEC: compute from the captured values. Register o_data and o_overflow. Set o_done to 1 and o_valid to 1, clear o_busy, and return to IDLE.
- Arithmetic is performed DATA_WIDTH+1 bits wide on the sign-extended captured operands.
  - Add: overflow when A and B have the same sign and the result sign differs from A.
  - Sub: overflow when A and B have different signs and the result sign differs from A.
- Overflow result:
  - SATURATE=1: o_data = 0x7F (max positive) if A is non-negative, else 0x80 (min negative).
  - SATURATE=0: o_data = low DATA_WIDTH bits of the sum.
- When there is no overflow, o_data is the exact result and o_overflow is 0.
- o_valid, o_data and o_overflow hold their values until the next accepted i_start or reset.
- i_start while busy (EXEC) is ignored; it is neither queued nor latched.
- Operand and i_sub changes after capture do not affect the in-flight result.

## Timing

- Reset (i_rst=0, asynchronous): o_data=0, o_overflow=0, o_valid=0, o_done=0, o_busy=0, internal registers=0, state=IDLE. Reset during EXEC aborts the operation with no o_done.
- Latency: i_start sampled at edge k gives o_busy=1 after edge k, and the result with o_done=1 and o_valid=1 after edge k+1.
- o_done is high for exactly one cycle per operation. o_busy is high for exactly one cycle per operation.
- The maximum issue rate is one operation per 2 cycles. i_start held continuously high produces an operation every 2 cycles, with results after edges k+1, k+3, …
- If i_start is high on the same edge that completes EXEC, it is ignored (the state is EXEC on that edge).
- No combinational path exists from any input to any output.

## Test plan

- Reset, then i_start=1 for one cycle with A=0x00, B=0x00, sub=0, then 20 idle cycles -> after edge k+1: o_data=0x00, o_overflow=0, o_done pulses once, o_valid stays 1, and o_busy is high for one cycle only.
- Add without overflow, A=0x10 (1.0), B=0x18 (1.5) -> o_data=0x28, o_overflow=0. Sub, A=0x10, B=0x18 -> o_data=0xF8 (−0.5), o_overflow=0.
- Overflow with SATURATE=1:
  - 0x70+0x20 -> o_data=0x7F, o_overflow=1.
  - sub 0x80−0x01 -> o_data=0x80, o_overflow=1.
  - 0x80+0x80 -> o_data=0x80, o_overflow=1.
  - With SATURATE=0, 0x70+0x20 -> o_data=0x90, o_overflow=1.
- Handshake: assert i_start again during EXEC with different operands -> ignored, result reflects the first operands. Change the operands right after capture -> result unchanged. Hold i_start high -> one o_done every 2 cycles.
- Drive i_rst low during EXEC -> all outputs 0 immediately (asynchronous), no o_done. After release, the next i_start runs normally.
